// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder: FSM state encoding,
// command opcodes and abort cause codes.
package uart_cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ERR_W  = 3;

  // Command opcodes (first byte of every frame)
  localparam logic [BYTE_W-1:0] CMD_WR = 8'hAA;
  localparam logic [BYTE_W-1:0] CMD_RD = 8'hBB;

  // Abort causes reported on err_code
  localparam logic [ERR_W-1:0] ERR_NONE = 3'd0;
  localparam logic [ERR_W-1:0] ERR_LINE = 3'd1;
  localparam logic [ERR_W-1:0] ERR_OPC  = 3'd2;
  localparam logic [ERR_W-1:0] ERR_ADDR = 3'd3;
  localparam logic [ERR_W-1:0] ERR_TMO  = 3'd4;
  localparam logic [ERR_W-1:0] ERR_OVR  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5
  } state_t;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte idle counter. Counts enabled cycles since the last clear and
// flags the cycle in which LIMIT idle cycles have been observed.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : reload the counter to zero (takes effect next cycle)
//   en         : count this cycle
//   tc_c       : terminal count reached (combinational, qualified by en)
// LIMIT = 0 disables the terminal count entirely.
module uart_frame_timer #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam int unsigned LAST  = (LIMIT > 0) ? LIMIT - 1 : 0;
  localparam logic        ARMED = (LIMIT != 0);

  logic [CNT_W-1:0] count;

  // Counter value k-1 in the k-th idle cycle after a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && ARMED && !tc_c) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc_c = ARMED && en && (count == CNT_W'(LAST));

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses 2/3-byte command frames from the UART receiver into register-file
// write/read strobes and forwards read data to the UART TX path.
// Ports:
//   clk, rst                 : clock, async active-low reset
//   rx_p_data/rx_data_valid  : received byte and its one-cycle valid
//   rx_parity/stop_error     : line error flags for the current byte
//   rf_wr_en/rf_rd_en        : one-cycle register strobes
//   rf_addr/rf_wr_data       : register address and write data (held)
//   rf_rd_data/rf_rd_valid   : register read return
//   tx_data/tx_valid/tx_ready: read-back byte handshake to TX
//   frame_err/err_code       : abort pulse and last abort cause (held)
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_p_data,
  input  logic              rx_data_valid,
  input  logic              rx_parity_error,
  input  logic              rx_stop_error,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic              rf_rd_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              frame_err,
  output logic [2:0]        err_code
);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   rf_addr_d;
  logic [DATA_W-1:0]   rf_wr_data_d;
  logic                rf_wr_en_d, rf_rd_en_d;
  logic [7:0]          tx_data_d;
  logic                tx_valid_d;
  logic                frame_err_d;
  logic [ERR_W-1:0]    err_code_d;

  logic                abort_c;
  logic [ERR_W-1:0]    abort_code_c;
  logic                line_err_c;
  logic                addr_ok_c;
  logic                timed_c;
  logic                tmo_c;

  assign line_err_c = rx_parity_error | rx_stop_error;
  // Address byte is legal only if no bits above ADDR_W are set
  assign addr_ok_c  = (32'(rx_p_data) >> ADDR_W) == 32'd0;
  assign timed_c    = (state == ST_WR_ADDR) || (state == ST_WR_DATA) ||
                      (state == ST_RD_ADDR);

  // Idle timer: cleared by every byte and whenever outside a timed state,
  // so each timed state is entered with a fresh count
  uart_frame_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst),
    .clr   (rx_data_valid | ~timed_c),
    .en    (timed_c),
    .tc_c  (tmo_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    rf_addr_d    = rf_addr;
    rf_wr_data_d = rf_wr_data;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    tx_data_d    = tx_data;
    tx_valid_d   = tx_valid;
    frame_err_d  = 1'b0;
    err_code_d   = err_code;
    abort_c      = 1'b0;
    abort_code_c = ERR_NONE;

    unique case (state)
      ST_IDLE: begin
        if (rx_data_valid) begin
          if (line_err_c) begin
            abort_c      = 1'b1;
            abort_code_c = ERR_LINE;
          end else if (rx_p_data == CMD_WR) begin
            state_d = ST_WR_ADDR;
          end else if (rx_p_data == CMD_RD) begin
            state_d = ST_RD_ADDR;
          end else begin
            abort_c      = 1'b1;
            abort_code_c = ERR_OPC;
          end
        end
      end

      ST_WR_ADDR, ST_RD_ADDR: begin
        // A byte in the same cycle as the timeout takes precedence
        if (rx_data_valid) begin
          if (line_err_c) begin
            abort_c      = 1'b1;
            abort_code_c = ERR_LINE;
          end else if (!addr_ok_c) begin
            abort_c      = 1'b1;
            abort_code_c = ERR_ADDR;
          end else begin
            rf_addr_d = rx_p_data[ADDR_W-1:0];
            if (state == ST_WR_ADDR) begin
              state_d = ST_WR_DATA;
            end else begin
              rf_rd_en_d = 1'b1;
              state_d    = ST_RD_WAIT;
            end
          end
        end else if (tmo_c) begin
          abort_c      = 1'b1;
          abort_code_c = ERR_TMO;
        end
      end

      ST_WR_DATA: begin
        if (rx_data_valid) begin
          if (line_err_c) begin
            abort_c      = 1'b1;
            abort_code_c = ERR_LINE;
          end else begin
            rf_wr_data_d = DATA_W'(rx_p_data);
            rf_wr_en_d   = 1'b1;
            state_d      = ST_IDLE;
          end
        end else if (tmo_c) begin
          abort_c      = 1'b1;
          abort_code_c = ERR_TMO;
        end
      end

      ST_RD_WAIT: begin
        // Overrun is reported but the pending read keeps going
        if (rx_data_valid) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVR;
        end
        if (rf_rd_valid) begin
          tx_data_d  = 8'(rf_rd_data);
          tx_valid_d = 1'b1;
          state_d    = ST_TX_SEND;
        end
      end

      ST_TX_SEND: begin
        if (rx_data_valid) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVR;
        end
        if (tx_valid && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_c) begin
      frame_err_d = 1'b1;
      err_code_d  = abort_code_c;
      state_d     = ST_IDLE;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_d;
      rf_addr    <= rf_addr_d;
      rf_wr_data <= rf_wr_data_d;
      rf_wr_en   <= rf_wr_en_d;
      rf_rd_en   <= rf_rd_en_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      frame_err  <= frame_err_d;
      err_code   <= err_code_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with an event scoreboard.
module tb_uart_cmd_decoder;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned TMO    = 10;

  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_RD  = 2'd1;
  localparam logic [1:0] K_TX  = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_p_data = '0;
  logic              rx_data_valid = 1'b0;
  logic              rx_parity_error = 1'b0;
  logic              rx_stop_error = 1'b0;
  logic              rf_wr_en, rf_rd_en;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [DATA_W-1:0] rf_rd_data = '0;
  logic              rf_rd_valid = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              frame_err;
  logic [2:0]        err_code;

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];

  uart_cmd_decoder #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_p_data       (rx_p_data),
    .rx_data_valid   (rx_data_valid),
    .rx_parity_error (rx_parity_error),
    .rx_stop_error   (rx_stop_error),
    .rf_wr_en        (rf_wr_en),
    .rf_rd_en        (rf_rd_en),
    .rf_addr         (rf_addr),
    .rf_wr_data      (rf_wr_data),
    .rf_rd_data      (rf_rd_data),
    .rf_rd_valid     (rf_rd_valid),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .frame_err       (frame_err),
    .err_code        (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [7:0] addr, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [1:0] kind, input logic [7:0] addr, input logic [7:0] data);
    ev_t e;
    check("sb_event_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_kind", 32'(kind), 32'(e.kind));
      check("sb_addr", 32'(addr), 32'(e.addr));
      check("sb_data", 32'(data), 32'(e.data));
    end
  endtask

  // Observe DUT events mid-cycle and match them against the expected queue
  always @(negedge clk) begin
    if (rst) begin
      if (rf_wr_en)            pop_cmp(K_WR, 8'(rf_addr), 8'(rf_wr_data));
      if (rf_rd_en)            pop_cmp(K_RD, 8'(rf_addr), 8'h00);
      if (frame_err)           pop_cmp(K_ERR, 8'h00, 8'(err_code));
      if (tx_valid && tx_ready) pop_cmp(K_TX, 8'h00, tx_data);
    end
  end

  // Byte is presented now and sampled at the next edge; returns just after it
  task automatic send_byte(input logic [7:0] b, input logic perr);
    rx_p_data       = b;
    rx_parity_error = perr;
    rx_data_valid   = 1'b1;
    @(posedge clk); #1;
    rx_data_valid   = 1'b0;
    rx_parity_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(2);
    check("rst_wr_en", 32'(rf_wr_en), 32'd0);
    check("rst_rd_en", 32'(rf_rd_en), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    rst = 1'b1;
    idle(2);

    // Write frame AA,03,5C with gaps
    push(K_WR, 8'h03, 8'h5C);
    send_byte(8'hAA, 1'b0);
    idle(3);
    send_byte(8'h03, 1'b0);
    idle(2);
    check("wr_no_early_strobe", 32'(rf_wr_en), 32'd0);
    send_byte(8'h5C, 1'b0);
    check("wr_strobe", 32'(rf_wr_en), 32'd1);
    check("wr_addr", 32'(rf_addr), 32'd3);
    check("wr_data", 32'(rf_wr_data), 32'h5C);
    check("wr_no_err", 32'(frame_err), 32'd0);
    idle(1);
    check("wr_strobe_one_cycle", 32'(rf_wr_en), 32'd0);

    // Read frame BB,07; data 2 cycles after rd_en; TX stalls 5 cycles
    push(K_RD, 8'h07, 8'h00);
    push(K_TX, 8'h00, 8'h9E);
    send_byte(8'hBB, 1'b0);
    send_byte(8'h07, 1'b0);
    check("rd_strobe", 32'(rf_rd_en), 32'd1);
    check("rd_addr", 32'(rf_addr), 32'd7);
    idle(1);
    check("rd_strobe_one_cycle", 32'(rf_rd_en), 32'd0);
    idle(1);
    rf_rd_data  = 8'h9E;
    rf_rd_valid = 1'b1;
    @(posedge clk); #1;
    rf_rd_valid = 1'b0;
    rf_rd_data  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("tx_hold_valid", 32'(tx_valid), 32'd1);
      check("tx_hold_data", 32'(tx_data), 32'h9E);
      idle(1);
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("tx_drop_valid", 32'(tx_valid), 32'd0);
    idle(2);

    // Bad opcode, then a normal write
    push(K_ERR, 8'h00, 8'd2);
    send_byte(8'h12, 1'b0);
    check("opc_frame_err", 32'(frame_err), 32'd1);
    check("opc_err_code", 32'(err_code), 32'd2);
    idle(1);
    check("opc_err_pulse", 32'(frame_err), 32'd0);
    check("opc_err_held", 32'(err_code), 32'd2);
    push(K_WR, 8'h01, 8'hFF);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hFF, 1'b0);
    check("wr2_strobe", 32'(rf_wr_en), 32'd1);
    idle(1);

    // Illegal address
    push(K_ERR, 8'h00, 8'd3);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h20, 1'b0);
    check("addr_err_code", 32'(err_code), 32'd3);
    idle(1);

    // Parity error on the address byte
    push(K_ERR, 8'h00, 8'd1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h02, 1'b1);
    check("line_err_code", 32'(err_code), 32'd1);
    check("line_no_wr", 32'(rf_wr_en), 32'd0);
    idle(1);

    // Timeout after 10 idle cycles
    push(K_ERR, 8'h00, 8'd4);
    send_byte(8'hAA, 1'b0);
    idle(9);
    check("tmo_not_yet", 32'(frame_err), 32'd0);
    idle(1);
    check("tmo_frame_err", 32'(frame_err), 32'd1);
    check("tmo_err_code", 32'(err_code), 32'd4);
    idle(1);

    // Byte exactly on the timeout cycle wins
    push(K_WR, 8'h03, 8'h44);
    send_byte(8'hAA, 1'b0);
    idle(9);
    send_byte(8'h03, 1'b0);
    check("tmo_byte_wins", 32'(frame_err), 32'd0);
    send_byte(8'h44, 1'b0);
    check("tmo_byte_wr", 32'(rf_wr_en), 32'd1);
    idle(1);

    // Overrun during RD_WAIT; the read still completes
    push(K_RD, 8'h05, 8'h00);
    send_byte(8'hBB, 1'b0);
    send_byte(8'h05, 1'b0);
    push(K_ERR, 8'h00, 8'd5);
    send_byte(8'h77, 1'b0);
    check("ovr_frame_err", 32'(frame_err), 32'd1);
    check("ovr_err_code", 32'(err_code), 32'd5);
    push(K_TX, 8'h00, 8'h3C);
    rf_rd_data  = 8'h3C;
    rf_rd_valid = 1'b1;
    @(posedge clk); #1;
    rf_rd_valid = 1'b0;
    check("ovr_tx_valid", 32'(tx_valid), 32'd1);
    check("ovr_tx_data", 32'(tx_data), 32'h3C);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    idle(1);

    // Reset in the middle of WR_DATA
    send_byte(8'hAA, 1'b0);
    send_byte(8'h06, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(rf_wr_en), 32'd0);
    check("mid_rst_addr", 32'(rf_addr), 32'd0);
    check("mid_rst_wdata", 32'(rf_wr_data), 32'd0);
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_err_code", 32'(err_code), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(1);
    // Former data byte now lands in IDLE and is a bad opcode
    push(K_ERR, 8'h00, 8'd2);
    send_byte(8'h99, 1'b0);
    check("post_rst_no_wr", 32'(rf_wr_en), 32'd0);
    check("post_rst_err", 32'(err_code), 32'd2);
    idle(3);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Consumes the UART receiver's parallel byte stream and parses 2- and 3-byte command frames into register-file write and read strobes.
- For read commands, the returned register data is handed to the UART transmit path through a valid/ready handshake.
- Sits between the receiver output and the register file / TX feed, in the receiver's clock domain.

Parameters:
- ADDR_W, 4, register-file address width; legal addresses are 0 .. 2^ADDR_W-1.
- DATA_W, 8, register data width; fixed to the UART byte width.
- TIMEOUT_CYCLES, 65535, idle clk cycles tolerated between bytes of one frame; 0 disables the timeout.
- CMD_WR, 8'hAA, write opcode.
- CMD_RD, 8'hBB, read opcode.

Ports:
- clk  in  1  clock, shared with the receiver.
- rst  in  1  asynchronous, active-low reset.
- rx_p_data  in  8  received byte.
- rx_data_valid  in  1  one-cycle pulse; rx_p_data is valid in that cycle.
- rx_parity_error  in  1  error flag accompanying the current byte.
- rx_stop_error  in  1  error flag accompanying the current byte.
- rf_wr_en  out  1  one-cycle register write strobe.
- rf_rd_en  out  1  one-cycle register read strobe.
- rf_addr  out  ADDR_W  register address.
- rf_wr_data  out  DATA_W  write data.
- rf_rd_data  in  DATA_W  read data.
- rf_rd_valid  in  1  qualifies rf_rd_data; may arrive 1+ cycles after rf_rd_en.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  held high until accepted.
- tx_ready  in  1  TX path can accept a byte.
- frame_err  out  1  one-cycle pulse on any aborted frame.
- err_code  out  3  cause of the last abort: 1 = line error, 2 = bad opcode, 3 = bad address, 4 = timeout, 5 = overrun; held until the next abort.

Behaviour:
- Reset (rst low, async): state IDLE; every output 0; timeout counter 0.
- A "byte" is a cycle where rx_data_valid=1. A byte with rx_parity_error or rx_stop_error set aborts the current frame with code 1 (also from IDLE). It is never interpreted.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE transitions:
  - byte==CMD_WR -> WR_ADDR.
  - byte==CMD_RD -> RD_ADDR.
  - any other byte -> abort, code 2; stay IDLE.
- WR_ADDR: on byte, if byte >= 2^ADDR_W abort with code 3. Otherwise latch rf_addr = byte[ADDR_W-1:0] and go to WR_DATA.
- WR_DATA: on byte, drive rf_wr_data = byte and rf_wr_en = 1 for exactly the next cycle, then go to IDLE. The write strobe appears 1 cycle after the data byte's valid.
- RD_ADDR: on a legal address byte, latch rf_addr, pulse rf_rd_en 1 cycle, then go to RD_WAIT. An illegal address aborts with code 3.
- RD_WAIT: on rf_rd_valid, latch tx_data = rf_rd_data, assert tx_valid, and go to TX_SEND.
- TX_SEND: tx_valid stays high and tx_data stays stable until a cycle with tx_valid & tx_ready. In that cycle the byte transfers, tx_valid drops next cycle, and the FSM returns to IDLE.
- Overrun: any byte arriving in RD_WAIT or TX_SEND is dropped and raises frame_err with code 5. The pending read still completes.
- Timeout: the counter runs only in WR_ADDR, WR_DATA and RD_ADDR. It clears on every byte and on state entry. Reaching TIMEOUT_CYCLES aborts with code 4. RD_WAIT and TX_SEND have no timeout.
- Abort: frame_err pulses 1 cycle, err_code updates in the same cycle, and the FSM goes to IDLE.
- No write or read strobe is ever issued for an aborted frame. rf_addr and rf_wr_data hold their last values.
- Simultaneous events:
  - A byte and a timeout in the same cycle: the byte wins.
  - rf_rd_valid and an overrun byte in the same cycle: both actions take effect.
- A mid-frame reset discards the partial frame with no strobes. A reset during TX_SEND drops tx_valid immediately.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - the state enum;
  - opcode constants CMD_WR and CMD_RD;
  - error-code constants ERR_LINE=1, ERR_OPC=2, ERR_ADDR=3, ERR_TMO=4, ERR_OVR=5.
- One natural sub-module, uart_frame_timer: a loadable idle counter with a clear input and a terminal-count output.
- The FSM and the datapath registers stay in the top module.

Test Plan:
- Bytes AA,03,5C at arbitrary spacing -> one rf_wr_en pulse with rf_addr=3 and rf_wr_data=0x5C, 1 cycle after the 0x5C valid; frame_err stays 0.
- Bytes BB,07, then rf_rd_valid 2 cycles after rf_rd_en with data 0x9E, tx_ready held low for 5 cycles -> rf_rd_en pulses once; tx_valid is held with tx_data=0x9E until tx_ready=1; exactly one transfer, then IDLE.
- Byte 0x12 in IDLE -> frame_err pulse, err_code=2, no strobes. Then AA,01,FF -> a normal write to address 1.
- Bytes AA,20 (ADDR_W=4) -> err_code=3. AA,02 with rx_parity_error on the 02 -> err_code=1. Neither frame issues a write.
- TIMEOUT_CYCLES=10, send AA then idle 10 cycles -> frame_err and err_code=4 at cycle 10. A byte exactly on cycle 10 instead -> no abort.
- A byte arriving during RD_WAIT -> err_code=5, and the read still returns its data on tx_data. Asserting rst mid-WR_DATA -> all outputs 0 immediately and no rf_wr_en.
